ibus_arbiter: RTL and testbench
===============================

IBUS_ARBITER -- requirements
Module: ibus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32 (InstAddrBus), address width.
REQ-002 SHALL have parameter DW, default 32 (InstBus), data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive debug grants allowed while fetch waits; legal range 1..15.
REQ-004 SHALL have one clock; reset is asynchronous and active-high. Ports: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-005 SHALL have ports:
- jtag_reset_flag_i  in  1  synchronous soft reset.
- flush_i  in  1  jump/flush; cancels the fetch result.
- if_req_i  in  1  fetch request.
- if_addr_i  in  AW  fetch address.
- if_gnt_o  out  1  fetch request accepted.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DW  fetch data.
- dbg_req_i  in  1  debug request.
- dbg_we_i  in  1  debug write.
- dbg_addr_i  in  AW  debug address.
- dbg_wdata_i  in  DW  debug write data.
- dbg_gnt_o  out  1  debug accepted.
- dbg_rvalid_o  out  1  debug response.
- dbg_rdata_o  out  DW  debug read data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_gnt_i  in  1  memory accept.
- mem_rvalid_i  in  1  memory response (at least 1 cycle after gnt).
- mem_rdata_i  in  DW  memory read data.
- busy_o  out  1  state != IDLE.

Function
REQ-006 SHALL allow at most one outstanding memory transaction.
REQ-007 SHALL implement states IDLE, WAIT_GNT, WAIT_RSP, DROP.
REQ-008 SHALL go IDLE->WAIT_GNT when any request is pending, latching the owner (FETCH/DBG) in that same cycle.
REQ-009 SHALL go WAIT_GNT->WAIT_RSP on mem_gnt_i, or WAIT_GNT->DROP on mem_gnt_i if the drop flag is set.
REQ-010 SHALL handle mem_rvalid_i in WAIT_RSP or DROP as follows: go to WAIT_GNT if a request is pending in that cycle (back-to-back), else go to IDLE.
REQ-011 SHALL, in WAIT_GNT, hold mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stable until mem_gnt_i; mem_req_o is driven combinationally in IDLE/WAIT_RSP on the arbitration cycle.
REQ-012 SHALL drive mem_addr_o = {if_addr_i[AW-1:2],2'b00} for fetch and mem_we_o=0 for fetch; debug address is passed unmodified.
REQ-013 SHALL assert if_gnt_o/dbg_gnt_o only in the cycle mem_gnt_i is high for that owner; requesters hold req and address until grant.
REQ-014 SHALL pass mem_rdata_i and mem_rvalid_i through combinationally to the owner; the non-owner rvalid stays 0.
REQ-015 SHALL give debug priority over fetch when both request in the same cycle (subject to REQ-021).
REQ-016 SHALL handle flush_i (or jtag_reset_flag_i) by owner state:
- FETCH in WAIT_RSP: go to DROP; the pending response is consumed with if_rvalid_o=0.
- FETCH in WAIT_GNT: set the drop flag.
- Same cycle as mem_rvalid_i: suppress if_rvalid_o.
REQ-017 SHALL ignore flush_i for DBG-owned transactions.
REQ-018 SHALL treat jtag_reset_flag_i as a flush for both owners and clear the starvation counter.
REQ-019 SHALL, with a request arriving in IDLE, respond by presenting mem_req_o in the same cycle (0-cycle issue latency).

Reset
REQ-020 SHALL, while rst_i is high, force state=IDLE, owner=FETCH, drop flag=0, counter=0, and drive all outputs to 0; mid-transaction reset abandons the transaction and a later stray mem_rvalid_i in IDLE is ignored.

Configuration
REQ-021 SHALL, with IBUS_ARB_STARVE_GUARD_EN defined, count consecutive debug grants while if_req_i is high; at STARVE_LIMIT the next arbitration picks fetch; the counter clears on a fetch grant or when if_req_i is low.
REQ-022 SHALL, without IBUS_ARB_STARVE_GUARD_EN, use strict debug priority with no counter logic.

Structure
REQ-023 SHALL place ibus_arb_state_e, the owner enum ibus_owner_e (FETCH/DBG) and AW/DW defaults in tinyriscv_pkg.
REQ-024 SHALL isolate the combinational priority/starvation pick in sub-module ibus_arb_pick.

Verification
REQ-025 SHALL cover single fetch: if_req_i=1, if_addr_i=0x102, gnt at cycle 1, rvalid at cycle 3 -> mem_addr_o=0x100, if_rvalid_o=1 with mem_rdata_i at cycle 3.
REQ-026 SHALL cover a simultaneous request: fetch and debug both requesting at 0x200 -> debug is granted first, fetch is granted on the cycle after debug rvalid.
REQ-027 SHALL cover a flush: flush_i in WAIT_RSP of a fetch -> state DROP, if_rvalid_o stays 0 when mem_rvalid_i=1, then IDLE.
REQ-028 SHALL cover starvation with the guard enabled and STARVE_LIMIT=4: 6 back-to-back debug requests with if_req_i high -> fetch is granted as the 5th transaction.
REQ-029 SHALL cover a reset in WAIT_GNT: rst_i pulse -> outputs 0 and state IDLE; a stray mem_rvalid_i next cycle produces no rvalid output.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared types and bus-width defaults for the instruction-bus arbiter.
package tinyriscv_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP,
    DROP
  } ibus_arb_state_e;

  typedef enum logic {
    FETCH,
    DBG
  } ibus_owner_e;

endpackage

// File: rtl/ibus_arb_pick.sv
// Combinational owner selection: debug wins unless the starvation flag hands the slot to fetch.
module ibus_arb_pick
  import tinyriscv_pkg::*;
(
  input  logic        if_req_i,
  input  logic        dbg_req_i,
  input  logic        starve_i,
  output logic        valid_o,
  output ibus_owner_e owner_o
);

  always_comb begin
    valid_o = if_req_i | dbg_req_i;
    owner_o = FETCH;
    if (dbg_req_i && !(starve_i && if_req_i)) begin
      owner_o = DBG;
    end
  end

endmodule

// File: rtl/ibus_arbiter.sv
// Single-outstanding arbiter between instruction fetch and debug onto one memory port.
// Define IBUS_ARB_STARVE_GUARD_EN to bound consecutive debug grants while fetch waits.
module ibus_arbiter
  import tinyriscv_pkg::*;
#(
  parameter int unsigned AW           = InstAddrBus,
  parameter int unsigned DW           = InstBus,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          jtag_reset_flag_i,
  input  logic          flush_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("ibus_arbiter: STARVE_LIMIT must be within 1..15");
  end

  ibus_arb_state_e state_q, state_d;
  ibus_owner_e     owner_q, owner_d;
  logic            drop_q, drop_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            starve;
  logic            pick_valid;
  ibus_owner_e     pick_owner;
  logic            arb_cycle;
  logic            issue;
  logic            kill;
  logic            pick_we;
  logic [AW-1:0]   pick_addr;
  logic [DW-1:0]   pick_wdata;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^if_addr_i[1:0];

`ifdef IBUS_ARB_STARVE_GUARD_EN
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (jtag_reset_flag_i || !if_req_i || if_gnt_o) begin
      cnt_d = '0;
    end else if (dbg_gnt_o && cnt_q != Limit) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign starve = (cnt_q >= Limit);
`else
  assign starve = 1'b0;
`endif

  ibus_arb_pick u_pick (
    .if_req_i  (if_req_i),
    .dbg_req_i (dbg_req_i),
    .starve_i  (starve),
    .valid_o   (pick_valid),
    .owner_o   (pick_owner)
  );

  // A new transaction may be issued from IDLE or in the response cycle of the current one.
  assign arb_cycle = !rst_i && ((state_q == IDLE) ||
                     ((state_q == WAIT_RSP || state_q == DROP) && mem_rvalid_i));
  assign issue     = arb_cycle && pick_valid;
  assign kill      = jtag_reset_flag_i || (flush_i && owner_q == FETCH);

  assign pick_we    = (pick_owner == DBG) && dbg_we_i;
  assign pick_addr  = (pick_owner == FETCH) ? {if_addr_i[AW-1:2], 2'b00} : dbg_addr_i;
  assign pick_wdata = (pick_owner == DBG) ? dbg_wdata_i : '0;

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if_gnt_o     = 1'b0;
    dbg_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    dbg_rvalid_o = 1'b0;
    if (!rst_i) begin
      if (state_q == WAIT_GNT) begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if_gnt_o    = mem_gnt_i && (owner_q == FETCH);
        dbg_gnt_o   = mem_gnt_i && (owner_q == DBG);
      end else if (issue) begin
        mem_req_o   = 1'b1;
        mem_we_o    = pick_we;
        mem_addr_o  = pick_addr;
        mem_wdata_o = pick_wdata;
        if_gnt_o    = mem_gnt_i && (pick_owner == FETCH);
        dbg_gnt_o   = mem_gnt_i && (pick_owner == DBG);
      end
      if (state_q == WAIT_RSP && mem_rvalid_i && !kill) begin
        if_rvalid_o  = (owner_q == FETCH);
        dbg_rvalid_o = (owner_q == DBG);
      end
    end
  end

  assign if_rdata_o  = if_rvalid_o  ? mem_rdata_i : '0;
  assign dbg_rdata_o = dbg_rvalid_o ? mem_rdata_i : '0;
  assign busy_o      = !rst_i && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      WAIT_GNT: begin
        if (kill) drop_d = 1'b1;
        if (mem_gnt_i) begin
          state_d = (drop_q || kill) ? DROP : WAIT_RSP;
          drop_d  = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) state_d = IDLE;
        else if (kill)    state_d = DROP;
      end
      DROP: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: ;
    endcase
    // A grant landing in the issue cycle itself is honoured so memory never sees a lost accept.
    if (issue) begin
      owner_d = pick_owner;
      we_d    = pick_we;
      addr_d  = pick_addr;
      wdata_d = pick_wdata;
      drop_d  = 1'b0;
      state_d = mem_gnt_i ? WAIT_RSP : WAIT_GNT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= FETCH;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IBUS_ARB_STARVE_GUARD_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IBUS_ARB_STARVE_GUARD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench for ibus_arbiter: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_ibus_arbiter;

  logic        clk = 1'b0;
  logic        rst, jtag, flush;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned dbg_grants;
  logic        fetch_done;
  logic        exp_dbg;

  always #5 clk = ~clk;

  ibus_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst), .jtag_reset_flag_i(jtag), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
    .dbg_rdata_o(dbg_rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; jtag = 1'b0; flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cyc(); cyc(); #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    if_req = 1'b0;
    cyc(); rst = 1'b0;

    // single fetch
    cyc(); if_req = 1'b1; if_addr = 32'h102; #1;
    chk1("sf_req_c0", mem_req, 1'b1);
    chk32("sf_addr_c0", mem_addr, 32'h100);
    chk1("sf_we_c0", mem_we, 1'b0);
    chk1("sf_busy_c0", busy, 1'b0);
    cyc(); mem_gnt = 1'b1; #1;
    chk1("sf_busy_c1", busy, 1'b1);
    chk32("sf_addr_c1", mem_addr, 32'h100);
    chk1("sf_if_gnt_c1", if_gnt, 1'b1);
    chk1("sf_dbg_gnt_c1", dbg_gnt, 1'b0);
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; #1;
    chk1("sf_req_c2", mem_req, 1'b0);
    chk1("sf_rvalid_c2", if_rvalid, 1'b0);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk1("sf_rvalid_c3", if_rvalid, 1'b1);
    chk32("sf_rdata_c3", if_rdata, 32'hDEADBEEF);
    chk1("sf_dbg_rvalid_c3", dbg_rvalid, 1'b0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk1("sf_busy_c4", busy, 1'b0);

    // simultaneous fetch and debug
    cyc(); if_req = 1'b1; if_addr = 32'h200;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'h55; #1;
    chk1("sim_we_c0", mem_we, 1'b1);
    chk32("sim_wdata_c0", mem_wdata, 32'h55);
    cyc(); mem_gnt = 1'b1; #1;
    chk1("sim_dbg_gnt", dbg_gnt, 1'b1);
    chk1("sim_if_gnt_early", if_gnt, 1'b0);
    cyc(); dbg_req = 1'b0; dbg_we = 1'b0; mem_gnt = 1'b0; #1;
    chk1("sim_if_gnt_wait", if_gnt, 1'b0);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h0; #1;
    chk1("sim_dbg_rvalid", dbg_rvalid, 1'b1);
    chk1("sim_if_rvalid_0", if_rvalid, 1'b0);
    chk1("sim_b2b_req", mem_req, 1'b1);
    chk32("sim_b2b_addr", mem_addr, 32'h200);
    cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
    chk1("sim_if_gnt", if_gnt, 1'b1);
    chk1("sim_busy", busy, 1'b1);
    cyc(); if_req = 1'b0; mem_gnt = 1'b0;
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    chk1("sim_if_rvalid", if_rvalid, 1'b1);
    chk32("sim_if_rdata", if_rdata, 32'h12345678);
    cyc(); mem_rvalid = 1'b0; #1;
    chk1("sim_idle", busy, 1'b0);

    // flush of a fetch in WAIT_RSP
    cyc(); if_req = 1'b1; if_addr = 32'h300;
    cyc(); mem_gnt = 1'b1;
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; flush = 1'b1; #1;
    chk1("fl_rvalid_c2", if_rvalid, 1'b0);
    cyc(); flush = 1'b0; #1;
    chk1("fl_busy_drop", busy, 1'b1);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
    chk1("fl_rvalid_drop", if_rvalid, 1'b0);
    chk32("fl_rdata_drop", if_rdata, 32'h0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk1("fl_idle", busy, 1'b0);

    // flush has no effect on a debug read
    cyc(); dbg_req = 1'b1; dbg_addr = 32'h603;
    cyc(); mem_gnt = 1'b1; #1;
    chk32("dfl_addr", mem_addr, 32'h603);
    cyc(); dbg_req = 1'b0; mem_gnt = 1'b0; flush = 1'b1;
    cyc(); flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000CAFE; #1;
    chk1("dfl_rvalid", dbg_rvalid, 1'b1);
    chk32("dfl_rdata", dbg_rdata, 32'h0000CAFE);
    cyc(); mem_rvalid = 1'b0;

    // back-to-back debug with fetch waiting
    cyc(); if_req = 1'b1; if_addr = 32'h400; dbg_req = 1'b1; dbg_addr = 32'h700;
    dbg_grants = 0; fetch_done = 1'b0;
    for (int k = 1; k <= 7; k++) begin
`ifdef IBUS_ARB_STARVE_GUARD_EN
      exp_dbg = (k != 5);
`else
      exp_dbg = (k != 7);
`endif
      cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
      chk1($sformatf("stv_dbg_gnt_%0d", k), dbg_gnt, exp_dbg);
      chk1($sformatf("stv_if_gnt_%0d", k), if_gnt, !exp_dbg);
      if (dbg_gnt) dbg_grants++;
      if (if_gnt) fetch_done = 1'b1;
      cyc(); mem_gnt = 1'b0;
      dbg_req = (dbg_grants < 6);
      if_req = !fetch_done;
      cyc(); mem_rvalid = 1'b1;
    end
    cyc(); mem_rvalid = 1'b0; #1;
    chk1("stv_idle", busy, 1'b0);

    // reset while waiting for grant
    cyc(); if_req = 1'b1; if_addr = 32'h500;
    cyc(); rst = 1'b1; #1;
    chk1("rg_mem_req", mem_req, 1'b0);
    chk1("rg_busy", busy, 1'b0);
    chk32("rg_addr", mem_addr, 32'h0);
    cyc(); rst = 1'b0; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11112222; #1;
    chk1("rg_stray_if", if_rvalid, 1'b0);
    chk1("rg_stray_dbg", dbg_rvalid, 1'b0);
    chk1("rg_stray_busy", busy, 1'b0);
    chk1("rg_stray_req", mem_req, 1'b0);
    cyc(); mem_rvalid = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
